// File: rtl/ctrl_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_link_pkg
// Brief    : Shared constants, FSM state type and the serial CRC-8 step for
//            the control-word SPI receive link.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_link_pkg;

    localparam int                 WORD_W     = 16;
    localparam int                 CRC_W      = 8;
    localparam logic [CRC_W-1:0]   CRC_POLY   = 8'h07;
    localparam logic [WORD_W-1:0]  SAFE_WORD  = 16'h0000;
    localparam int                 FRAME_BITS = 24;

    // Bit counter must hold FRAME_BITS+1 so over-long frames are visible.
    localparam int                     BIT_CNT_W     = 5;
    localparam logic [BIT_CNT_W-1:0]   BIT_CNT_SAT   = 5'd25;
    localparam logic [BIT_CNT_W-1:0]   BIT_CNT_FRAME = 5'(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0]   BIT_CNT_WORD  = 5'(WORD_W);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_CHECK     = 2'd3
    } rx_state_e;

    // One bit of an MSB-first CRC-8: init 0, no reflection, no final XOR.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Multi-flop synchroniser for one asynchronous input, with
//            rise/fall strobes derived from the synchronised level.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_d;
    logic                   prev_q;

    // Shift the raw input along the synchroniser chain; remember last level.
    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Chain and edge-history flops; RESET_VAL avoids a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_word_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_word_spi_rx
// Brief    : Mode-0 SPI slave receiving 16-bit control word + CRC-8 frames,
//            with a link watchdog that forces a safe word on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_word_spi_rx
    import ctrl_link_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              crc_err,
    output logic              frame_err,
    output logic              link_lost
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic sclk_lvl;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic unused_sync;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs_n resets to "selected" so a frame already running at reset is
    // never mistaken for idle before the real line level has propagated.
    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign unused_sync = sclk_lvl ^ sclk_fall;

    // mosi shares the sclk chain depth so data aligns with the detected rise.
    logic [SYNC_STAGES-1:0] mosi_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    // Advance the mosi synchroniser chain.
    always_comb begin
        mosi_sync_d[0] = spi_mosi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            mosi_sync_d[i] = mosi_sync_q[i-1];
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM, shift/CRC datapath and watchdog
    // ------------------------------------------------------------------
    rx_state_e                 state_d,      state_q;
    logic [BIT_CNT_W-1:0]      bit_cnt_d,    bit_cnt_q;
    logic [FRAME_BITS-1:0]     shift_reg_d,  shift_reg_q;
    logic [CRC_W-1:0]          crc_d,        crc_q;
    logic [WORD_W-1:0]         word_out_d,   word_out_q;
    logic                      word_valid_d, word_valid_q;
    logic                      crc_err_d,    crc_err_q;
    logic                      frame_err_d,  frame_err_q;
    logic                      link_lost_d,  link_lost_q;
    logic [WD_W-1:0]           wd_cnt_d,     wd_cnt_q;
    logic                      frame_ok;

    // Next-state logic for the receiver, its datapath and the watchdog.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_reg_d  = shift_reg_q;
        crc_d        = crc_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        crc_err_d    = 1'b0;
        frame_err_d  = 1'b0;
        link_lost_d  = link_lost_q;
        frame_ok     = 1'b0;
        wd_cnt_d     = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);

        case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d   = '0;
                    shift_reg_d = '0;
                    crc_d       = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // End of frame takes priority over a coincident sclk rise.
                if (cs_rise) begin
                    state_d = ST_CHECK;
                end else if (sclk_rise) begin
                    if (bit_cnt_q < BIT_CNT_FRAME) begin
                        shift_reg_d = {shift_reg_q[FRAME_BITS-2:0], mosi_s};
                    end
                    if (bit_cnt_q < BIT_CNT_WORD) begin
                        crc_d = crc8_step(crc_q, mosi_s);
                    end
                    if (bit_cnt_q != BIT_CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (bit_cnt_q != BIT_CNT_FRAME) begin
                    frame_err_d = 1'b1;
                end else if (crc_q == shift_reg_q[CRC_W-1:0]) begin
                    frame_ok = 1'b1;
                end else begin
                    crc_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        // A valid frame on the expiry cycle beats the watchdog.
        if (frame_ok) begin
            word_out_d   = shift_reg_q[FRAME_BITS-1:CRC_W];
            word_valid_d = 1'b1;
            link_lost_d  = 1'b0;
            wd_cnt_d     = '0;
        end else if (wd_cnt_d == WD_MAX) begin
            link_lost_d  = 1'b1;
            word_out_d   = SAFE_WORD;
        end
    end

    // State and output registers; reset parks the link in the safe state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_IDLE;
            bit_cnt_q    <= '0;
            shift_reg_q  <= '0;
            crc_q        <= '0;
            word_out_q   <= SAFE_WORD;
            word_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            link_lost_q  <= 1'b1;
            wd_cnt_q     <= '0;
            mosi_sync_q  <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_reg_q  <= shift_reg_d;
            crc_q        <= crc_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            crc_err_q    <= crc_err_d;
            frame_err_q  <= frame_err_d;
            link_lost_q  <= link_lost_d;
            wd_cnt_q     <= wd_cnt_d;
            mosi_sync_q  <= mosi_sync_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign crc_err    = crc_err_q;
    assign frame_err  = frame_err_q;
    assign link_lost  = link_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_word_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_word_spi_rx
// Brief    : Directed self-checking bench for the control-word SPI receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_word_spi_rx;

    localparam int TIMEOUT = 1000;
    localparam int HALF    = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        crc_err;
    logic        frame_err;
    logic        link_lost;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_wv  = 0;
    int n_ce  = 0;
    int n_fe  = 0;
    int last_wv_cyc = 0;
    int wv0, ce0, fe0, t0, t1;

    always #5 clk = ~clk;

    ctrl_word_spi_rx #(
        .TIMEOUT_CYC (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .word_out   (word_out),
        .word_valid (word_valid),
        .crc_err    (crc_err),
        .frame_err  (frame_err),
        .link_lost  (link_lost)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Count high cycles of every pulse output, shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (word_valid === 1'b1) begin
            n_wv        <= n_wv + 1;
            last_wv_cyc <= cyc;
        end
        if (crc_err === 1'b1)   n_ce <= n_ce + 1;
        if (frame_err === 1'b1) n_fe <= n_fe + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            spi_mosi = v[i];
            tick(HALF);
            spi_sclk = 1'b1;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] v, input int hi, input int lo);
        spi_cs_n = 1'b0;
        tick(HALF);
        send_bits(v, hi, lo);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(12);
    endtask

    task automatic snap;
        wv0 = n_wv;
        ce0 = n_ce;
        fe0 = n_fe;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        // 1: reset with cs_n held low, then a full frame that must be discarded
        tick(3);
        check("rst_word_out", word_out, 16'h0000);
        check("rst_link_lost", link_lost, 1);
        check("rst_pulses", {word_valid, crc_err, frame_err}, 0);
        rst_n = 1'b1;
        tick(4);
        send_bits(32'h1234F1, 23, 0);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(12);
        check("t1_no_pulses", n_wv + n_ce + n_fe, 0);
        check("t1_word_out", word_out, 16'h0000);
        check("t1_link_lost", link_lost, 1);

        // 2: valid frame with exact latency from cs_n rise
        snap();
        spi_cs_n = 1'b0;
        tick(HALF);
        send_bits(32'h1234F1, 23, 0);
        tick(HALF);
        spi_cs_n = 1'b1;
        t0 = cyc;
        wait_cyc(t0 + 3);
        check("t2_wv_early", word_valid, 0);
        wait_cyc(t0 + 4);
        check("t2_wv_on_time", word_valid, 1);
        check("t2_word_out", word_out, 16'h1234);
        check("t2_link_lost", link_lost, 0);
        tick(10);
        check("t2_wv_count", n_wv - wv0, 1);
        check("t2_err_count", (n_ce - ce0) + (n_fe - fe0), 0);

        // 3: CRC mismatch
        snap();
        frame(32'h1234F0, 23, 0);
        check("t3_crc_err", n_ce - ce0, 1);
        check("t3_other", (n_wv - wv0) + (n_fe - fe0), 0);
        check("t3_word_out", word_out, 16'h1234);

        // 4: 23-bit and 25-bit frames (the 25-bit one has a valid first 24 bits)
        snap();
        frame(32'h00FFF3, 23, 1);
        check("t4a_frame_err", n_fe - fe0, 1);
        check("t4a_word_out", word_out, 16'h1234);
        snap();
        frame({7'd0, 24'h00FFF3, 1'b1}, 24, 0);
        check("t4b_frame_err", n_fe - fe0, 1);
        check("t4b_other", (n_wv - wv0) + (n_ce - ce0), 0);
        check("t4b_word_out", word_out, 16'h1234);

        // second data pattern
        snap();
        frame(32'h00FFF3, 23, 0);
        check("t4c_wv", n_wv - wv0, 1);
        check("t4c_word_out", word_out, 16'h00FF);

        // 5a: timeout exactly TIMEOUT clk after the load; an error frame
        //     in between must not feed the watchdog
        t0 = last_wv_cyc;
        snap();
        frame(32'h1234F0, 23, 0);
        check("t5a_crc_err", n_ce - ce0, 1);
        wait_cyc(t0 + TIMEOUT - 1);
        check("t5a_ll_before", link_lost, 0);
        check("t5a_word_before", word_out, 16'h00FF);
        wait_cyc(t0 + TIMEOUT);
        check("t5a_ll_expiry", link_lost, 1);
        check("t5a_word_expiry", word_out, 16'h0000);

        // 5b: a valid frame whose CHECK lands on the expiry cycle wins
        frame(32'h00FFF3, 23, 0);
        check("t5b_relink", link_lost, 0);
        t1 = last_wv_cyc;
        snap();
        spi_cs_n = 1'b0;
        tick(HALF);
        send_bits(32'h1234F1, 23, 0);
        tick(HALF);
        wait_cyc(t1 + TIMEOUT - 4);
        spi_cs_n = 1'b1;
        wait_cyc(t1 + TIMEOUT);
        check("t5b_wv", word_valid, 1);
        check("t5b_ll", link_lost, 0);
        check("t5b_word_out", word_out, 16'h1234);
        tick(5);
        check("t5b_ll_after", link_lost, 0);

        // 6: reset mid-frame at bit 12, finish the frame, then a clean frame
        snap();
        spi_cs_n = 1'b0;
        tick(HALF);
        send_bits(32'h00FFF3, 23, 12);
        rst_n = 1'b0;
        tick(2);
        check("t6_rst_word", word_out, 16'h0000);
        check("t6_rst_ll", link_lost, 1);
        rst_n = 1'b1;
        send_bits(32'h00FFF3, 11, 0);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(12);
        check("t6_no_pulses", (n_wv - wv0) + (n_ce - ce0) + (n_fe - fe0), 0);
        check("t6_ll_held", link_lost, 1);
        snap();
        frame(32'h00FFF3, 23, 0);
        check("t6_next_wv", n_wv - wv0, 1);
        check("t6_next_word", word_out, 16'h00FF);
        check("t6_next_ll", link_lost, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
